// File: rtl/pc_unit.sv
// Program counter with registered increment tap, two-byte staged jump load and
// a tri-state address-bus driver. Protocol misuse raises a sticky seq_err.
module pc_unit (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [15:0] addr_bus,
  input  logic [7:0]  data_bus,
  input  logic        pc_oe,
  input  logic        pc_wr,
  input  logic        pc_inc_en,
  input  logic        pc_inc_tap_en,
  input  logic        pc_ld16,
  input  logic        pc_ldl,
  input  logic        pc_ldh,
  output logic [15:0] pc_q,
  output logic        seq_err
);

  logic [15:0] pc;
  logic [15:0] inc_reg;
  logic        inc_valid;
  logic [7:0]  stage_lo;
  logic        stage_valid;

  assign addr_bus = pc_oe ? pc : 16'hzzzz;
  assign pc_q     = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= 16'h0000;
      inc_reg     <= 16'h0000;
      inc_valid   <= 1'b0;
      stage_lo    <= 8'h00;
      stage_valid <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      if (pc_wr) begin
        if (pc_inc_en) begin
          // pc is reloaded from inc_reg, so a held commit only advances once
          if (inc_valid) pc <= inc_reg;
          else           seq_err <= 1'b1;
        end else if (pc_ld16) begin
          // reading our own driven value back would be a bus self-loop
          if (!pc_oe) begin
            pc          <= addr_bus;
            inc_valid   <= 1'b0;
            stage_valid <= 1'b0;
          end else begin
            seq_err <= 1'b1;
          end
        end else if (pc_ldh) begin
          if (stage_valid) begin
            pc          <= {data_bus, stage_lo};
            stage_valid <= 1'b0;
            inc_valid   <= 1'b0;
          end else begin
            seq_err <= 1'b1;
          end
        end else if (pc_ldl) begin
          stage_lo    <= data_bus;
          stage_valid <= 1'b1;
        end
      end
      // placed last so a same-cycle tap overrides any inc_valid clear above
      if (pc_inc_tap_en) begin
        inc_reg   <= pc + 16'd1;
        inc_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: vector table driven through a scoreboard queue, plus
// hand sequences for reset, unprimed commit and mid-cycle reset corners.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_bus = 8'h00;
  logic        pc_oe = 1'b1;
  logic        pc_wr = 1'b0, pc_inc_en = 1'b0, pc_inc_tap_en = 1'b0;
  logic        pc_ld16 = 1'b0, pc_ldl = 1'b0, pc_ldh = 1'b0;
  logic [15:0] abus_drv = 16'h0000;
  logic [15:0] pc_q;
  logic        seq_err;
  wire  [15:0] addr_bus;

  assign addr_bus = pc_oe ? 16'hzzzz : abus_drv;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .addr_bus(addr_bus), .data_bus(data_bus),
    .pc_oe(pc_oe), .pc_wr(pc_wr), .pc_inc_en(pc_inc_en),
    .pc_inc_tap_en(pc_inc_tap_en), .pc_ld16(pc_ld16), .pc_ldl(pc_ldl),
    .pc_ldh(pc_ldh), .pc_q(pc_q), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        oe, wr, inc, tap, ld16, ldl, ldh;
    logic [7:0]  data;
    logic [15:0] abus;
    logic [15:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic oe, wr, inc, tap, ld16, ldl, ldh,
                     input logic [7:0] data, input logic [15:0] abus,
                     input logic [15:0] epc, input logic eerr);
    vec_t v;
    v.id = vecs.size(); v.oe = oe; v.wr = wr; v.inc = inc; v.tap = tap;
    v.ld16 = ld16; v.ldl = ldl; v.ldh = ldh; v.data = data; v.abus = abus;
    v.exp_pc = epc; v.exp_err = eerr;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge; the monitor checks after the next rising edge.
  task automatic run(input vec_t v);
    @(negedge clk);
    pc_oe = v.oe; pc_wr = v.wr; pc_inc_en = v.inc; pc_inc_tap_en = v.tap;
    pc_ld16 = v.ld16; pc_ldl = v.ldl; pc_ldh = v.ldh;
    data_bus = v.data; abus_drv = v.abus;
    exp_q.push_back(v);
  endtask

  task automatic idle();
    @(negedge clk);
    pc_wr = 1'b0; pc_inc_en = 1'b0; pc_inc_tap_en = 1'b0;
    pc_ld16 = 1'b0; pc_ldl = 1'b0; pc_ldh = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk($sformatf("vec%0d pc_q", mon_e.id), pc_q, mon_e.exp_pc);
      chk($sformatf("vec%0d seq_err", mon_e.id), {15'd0, seq_err}, {15'd0, mon_e.exp_err});
      if (mon_e.oe) chk($sformatf("vec%0d addr_bus", mon_e.id), addr_bus, mon_e.exp_pc);
    end
  end

  initial begin
    vec_t h;
    int   n;
    //   oe wr in tp 16 lo hi data   abus      pc        err
    add(1, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0); // tap at 0
    add(1, 1, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0001, 0); // commit held x3
    add(1, 1, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0001, 0);
    add(1, 1, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0001, 0);
    add(1, 1, 0, 0, 0, 1, 0, 8'h50, 16'h0000, 16'h0001, 0); // ldl 50
    add(1, 1, 0, 0, 0, 0, 1, 8'h01, 16'h0000, 16'h0150, 0); // ldh 01
    add(0, 1, 0, 0, 1, 0, 0, 8'h00, 16'hFFFF, 16'hFFFF, 0); // ld16 FFFF
    add(0, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, 16'hFFFF, 0); // tap
    add(0, 1, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0); // wrap
    add(0, 1, 0, 0, 1, 0, 0, 8'h00, 16'h0010, 16'h0010, 0); // ld16 0010
    add(0, 0, 0, 1, 0, 0, 0, 8'h00, 16'h0000, 16'h0010, 0); // tap
    add(0, 1, 1, 0, 1, 0, 0, 8'h00, 16'h1234, 16'h0011, 0); // inc beats ld16
    add(1, 1, 0, 0, 0, 1, 0, 8'h34, 16'h0000, 16'h0011, 0); // ldl 34
    add(1, 1, 0, 0, 0, 1, 1, 8'h56, 16'h0000, 16'h5634, 0); // ldh beats ldl
    add(0, 1, 0, 0, 0, 0, 0, 8'h99, 16'hBEEF, 16'h5634, 0); // wr, no select
    add(0, 1, 0, 1, 1, 0, 0, 8'h00, 16'h2000, 16'h2000, 0); // ld16 + tap
    add(0, 1, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h5635, 0); // tap survived
    add(1, 1, 0, 0, 1, 0, 0, 8'h00, 16'h0000, 16'h5635, 1); // ld16 contention
    add(1, 1, 0, 0, 0, 0, 1, 8'h77, 16'h0000, 16'h5635, 1); // ldh unstaged
    add(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h5635, 1); // sticky

    // reset state, with addr_bus driven by pc_oe during reset
    #12;
    chk("reset pc_q", pc_q, 16'h0000);
    chk("reset seq_err", {15'd0, seq_err}, 16'h0000);
    chk("reset addr_bus", addr_bus, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) run(vecs[i]);
    idle();

    // async reset clears sticky error immediately
    #2 rst_n = 1'b0; #1;
    chk("async rst pc_q", pc_q, 16'h0000);
    chk("async rst seq_err", {15'd0, seq_err}, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    // commit without a tap
    h = vecs[1]; h.id = 100; h.exp_pc = 16'h0000; h.exp_err = 1'b1;
    run(h);
    h.id = 101; h.wr = 1'b0; h.inc = 1'b0; run(h);
    h.id = 102; run(h);
    idle();
    chk("unprimed err held", {15'd0, seq_err}, 16'h0001);
    #2 rst_n = 1'b0; #1;
    chk("err cleared by reset", {15'd0, seq_err}, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    // staged low byte lost to a mid-cycle reset
    h = vecs[4]; h.id = 200; h.data = 8'hAA; h.exp_pc = 16'h0000; h.exp_err = 1'b0;
    run(h);
    @(posedge clk); #3;
    pc_wr = 1'b0; pc_ldl = 1'b0; rst_n = 1'b0; #1;
    chk("midcycle rst pc_q", pc_q, 16'h0000);
    rst_n = 1'b1;
    h = vecs[5]; h.id = 201; h.data = 8'h12; h.exp_pc = 16'h0000; h.exp_err = 1'b1;
    run(h);
    idle();

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 addr_bus  inout  16  shared address bus; driven by this block only while pc_oe=1, else high-Z.
REQ-004 data_bus  input  8  memory data bus; byte source for immediate PC loads.
REQ-005 pc_oe  input  1  drive pc onto addr_bus (combinational).
REQ-006 pc_wr  input  1  write strobe, level-sensitive; qualifies pc_inc_en, pc_ld16, pc_ldh, pc_ldl.
REQ-007 pc_inc_en  input  1  with pc_wr: pc <= inc_reg (commit increment).
REQ-008 pc_inc_tap_en  input  1  capture pc+1 into inc_reg.
REQ-009 pc_ld16  input  1  with pc_wr: pc <= addr_bus.
REQ-010 pc_ldl  input  1  with pc_wr: stage low byte from data_bus.
REQ-011 pc_ldh  input  1  with pc_wr: pc <= {data_bus, stage_lo} (atomic jump commit).
REQ-012 pc_q  output  16  registered current PC (debug/observability).
REQ-013 seq_err  output  1  sticky protocol-error flag.

Function
REQ-014 Internal state SHALL be: pc[15:0], inc_reg[15:0], inc_valid, stage_lo[7:0], stage_valid, seq_err.
REQ-015 addr_bus SHALL equal pc when pc_oe=1 and 16'hzzzz otherwise, with no clock latency.
REQ-016 On a clk edge with pc_inc_tap_en=1, inc_reg SHALL load (pc+1) mod 2^16 using pre-edge pc, and inc_valid SHALL set.
REQ-017 Write priority when pc_wr=1: pc_inc_en > pc_ld16 > pc_ldh > pc_ldl; lower-priority selects in the same cycle are ignored.
REQ-018 pc_wr=1 with no select asserted SHALL leave all state unchanged.
REQ-019 Increment commit (pc_wr & pc_inc_en & inc_valid): pc <= inc_reg; inc_valid remains set, so holding the commit for N cycles yields exactly one increment (idempotent).
REQ-020 Increment commit with inc_valid=0: pc SHALL be unchanged and seq_err SHALL set.
REQ-021 ld16 (pc_wr & pc_ld16 & !pc_oe): pc <= addr_bus; inc_valid and stage_valid clear.
REQ-022 ld16 while pc_oe=1 (self-contention): pc SHALL be unchanged and seq_err SHALL set.
REQ-023 ldl: stage_lo <= data_bus, stage_valid set; pc unchanged.
REQ-024 ldh with stage_valid=1: pc <= {data_bus, stage_lo}; stage_valid and inc_valid clear.
REQ-025 ldh with stage_valid=0: pc SHALL be unchanged and seq_err SHALL set.
REQ-026 Tap and write in the same cycle: the tap SHALL use pre-edge pc; if the write clears inc_valid, the tap's set SHALL take precedence (inc_valid=1 after edge).
REQ-027 Wrap-around: pc=16'hFFFF tap then commit SHALL give pc=16'h0000 with no error.
REQ-028 seq_err SHALL clear only on reset.
REQ-029 pc_q SHALL equal pc at all times.

Reset
REQ-030 While rst_n=0 (asynchronously on assertion): pc=16'h0000, inc_reg=16'h0000, inc_valid=0, stage_lo=8'h00, stage_valid=0, seq_err=0.
REQ-031 Reset asserted mid-operation (e.g. between ldl and ldh) SHALL discard staged data; a subsequent ldh SHALL flag seq_err.
REQ-032 addr_bus drive SHALL depend only on pc_oe, including during reset (drives 16'h0000 if pc_oe=1).

Verification
REQ-033 Reset, pc_oe=1, tap 1 cycle, then pc_wr+pc_inc_en held 3 cycles -> pc_q=16'h0001, addr_bus=16'h0001, seq_err=0.
REQ-034 ldl with data_bus=8'h50, then ldh with data_bus=8'h01 -> pc_q=16'h0150 after the ldh edge; pc unchanged after the ldl edge.
REQ-035 Drive addr_bus=16'hFFFF with pc_oe=0, ld16, then tap and commit -> pc_q=16'h0000, seq_err=0.
REQ-036 Commit pc_inc_en with no prior tap after reset -> pc_q=16'h0000, seq_err=1; seq_err stays 1 until rst_n low.
REQ-037 pc_wr with pc_inc_en=1 and pc_ld16=1 simultaneously after tap at pc=16'h0010 -> pc_q=16'h0011 (increment wins); ld16 with pc_oe=1 -> pc unchanged, seq_err=1.
REQ-038 ldl 8'hAA, rst_n pulsed low mid-cycle, then ldh 8'h12 -> pc_q=16'h0000, seq_err=1.
